movsum_inv: RTL and testbench
=============================

Name: movsum_inv

Overview:
- Inverse of the two-lane 4-tap moving-sum encoder (movavg); the decoder at the far end of that link.
- Accepts one pair of 64-bit moving sums per handshake and reconstructs the original sample pair exactly, modulo 2^64.
- Sits after movavg on the receive path; the encoder/decoder pair round-trips any sample stream bit-exactly.

Parameters:
W, 64, sample/sum width in bits
CNTW, 16, width of the decoded-pair counter

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset)
clear  input  1  synchronous flush of history and output stage
sumA  input  W  moving sum A(n)+B(n)+A(n-1)+B(n-1)
sumB  input  W  moving sum B(n)+A(n-1)+B(n-1)+A(n-2)
in_valid  input  1  sumA/sumB valid
in_ready  output  1  decoder can accept this cycle
outA  output  W  reconstructed A(n)
outB  output  W  reconstructed B(n)
out_valid  output  1  outA/outB valid
out_ready  input  1  downstream accepts outA/outB
pairs  output  CNTW  count of accepted pairs, wraps modulo 2^CNTW

Behaviour:
- Sample order: B(n) is the earlier sample of each pair. The serial stream is ..., B(n-1), A(n-1), B(n), A(n).
- Clock and reset:
  - Single clock domain.
  - Reset is sampled on the rising clk edge when reset==0.
  - Reset and clear both take effect on the same edge they are sampled; there is no asynchronous path.
- Reset values: outA=0, outB=0, out_valid=0, pairs=0, history registers hA1=hB1=hA2=0. History zero matches the encoder's zero-tap start.
- in_ready = reset & ~clear & (~out_valid | out_ready). This is combinational, so a full-throughput stream with no bubbles is possible.
- Accept condition: in_valid & in_ready on a rising edge.
- On accept, all arithmetic is modulo 2^W (wrapping subtract, no saturation):
  - B = sumB - hA1 - hB1 - hA2
  - A = sumA - B - hA1 - hB1
  - outB<=B, outA<=A, out_valid<=1.
  - hA2<=hA1, hA1<=A, hB1<=B.
  - pairs<=pairs+1.
- Latency: exactly 1 cycle from accept to out_valid.
- Output stage:
  - When out_valid & ~out_ready, outA, outB and out_valid hold, and no accept occurs (in_ready=0).
  - When out_ready=1 with no accept, out_valid<=0 and outA/outB hold their last value.
  - Simultaneous drain and accept loads the new pair, so out_valid stays 1.
- History advances only on accept. in_valid without in_ready has no effect; sumA/sumB may change freely while in_ready=0.
- clear=1 (with reset=1):
  - hA1, hB1, hA2 and out_valid go to 0, and pairs goes to 0.
  - in_ready=0 in that cycle, so an input presented together with clear is dropped.
  - outA/outB hold.
- reset mid-stream: identical to the reset values; any pending output is discarded. Priority is reset > clear > accept.
- Counter: pairs wraps from 2^CNTW-1 to 0 with no flag.
- No internal state other than the output register, three history registers and the counter. There is no FSM beyond the valid/ready register.

Test Plan:
1. Reset, then pairs (A,B)=(1,2), then (3,4), with out_ready=1:
   - Sums are (3,2) then (10,7).
   - Outputs are (1,2) then (3,4), each one cycle after its accept.
   - pairs=2.
2. Wrap: history A(n-1)=1, B(n-1)=2, A(n-2)=0, apply sumA=0, sumB=0:
   - outB=64'hFFFF_FFFF_FFFF_FFFD, outA=0.
3. Back-to-back round trip with movavg: 256 cycles of $random pairs, movavg outputs fed straight in, out_ready=1 throughout:
   - Every outA/outB equals the encoder input of the previous cycle.
   - in_ready stays 1 throughout.
4. Backpressure: out_ready=0 for 3 cycles with in_valid=1:
   - in_ready=0, and outA/outB/out_valid/history remain frozen.
   - On release, the next pair decodes correctly with no duplicate or skip.
5. Flush and reset mid-stream:
   - clear pulse after 5 pairs: out_valid=0, pairs=0, the simultaneous input is dropped, and a subsequent encoder restart from zero taps decodes correctly.
   - Repeat with reset=0 mid-stream: same result, with outA=outB=0.
6. Counter wrap with CNTW=4: after 16 accepted pairs, pairs=0; after 17, pairs=1.

Source files
------------

// File: rtl/movsum_inv.sv
// Two-lane 4-tap moving-sum decoder: rebuilds the (A,B) sample pair
// from each pair of moving sums, with a one-entry valid/ready output stage.
module movsum_inv #(
    parameter int W    = 64,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic [W-1:0]    sumA,
    input  logic [W-1:0]    sumB,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    outA,
    output logic [W-1:0]    outB,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CNTW-1:0] pairs
);

    localparam logic [CNTW-1:0] ONE = CNTW'(1);

    logic [W-1:0] hA1;
    logic [W-1:0] hB1;
    logic [W-1:0] hA2;
    logic [W-1:0] dec_a;
    logic [W-1:0] dec_b;
    logic         accept;

    assign in_ready = reset & ~clear & (~out_valid | out_ready);
    assign accept   = in_valid & in_ready;

    // B is the earlier sample, so it is peeled off first and reused for A
    assign dec_b = sumB - hA1 - hB1 - hA2;
    assign dec_a = sumA - dec_b - hA1 - hB1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            outA      <= '0;
            outB      <= '0;
            out_valid <= 1'b0;
            pairs     <= '0;
            hA1       <= '0;
            hB1       <= '0;
            hA2       <= '0;
        end else if (clear) begin
            out_valid <= 1'b0;
            pairs     <= '0;
            hA1       <= '0;
            hB1       <= '0;
            hA2       <= '0;
        end else if (accept) begin
            outA      <= dec_a;
            outB      <= dec_b;
            out_valid <= 1'b1;
            pairs     <= pairs + ONE;
            hA2       <= hA1;
            hA1       <= dec_a;
            hB1       <= dec_b;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_movsum_inv.sv
// Self-checking bench for movsum_inv: encoder model drives sums,
// expected sample pairs go through a scoreboard queue.
module tb_movsum_inv;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [63:0] sumA;
    logic [63:0] sumB;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] outA;
    logic [63:0] outB;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] pairs;

    logic        rdy4;
    logic [63:0] a4;
    logic [63:0] b4;
    logic        v4;
    logic [3:0]  p4;

    always #5 clk = ~clk;

    movsum_inv #(.W(64), .CNTW(16)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .sumA(sumA), .sumB(sumB), .in_valid(in_valid),
        .in_ready(in_ready), .outA(outA), .outB(outB),
        .out_valid(out_valid), .out_ready(out_ready), .pairs(pairs)
    );

    movsum_inv #(.W(64), .CNTW(4)) dut4 (
        .clk(clk), .reset(reset), .clear(clear),
        .sumA(sumA), .sumB(sumB), .in_valid(in_valid),
        .in_ready(rdy4), .outA(a4), .outB(b4),
        .out_valid(v4), .out_ready(out_ready), .pairs(p4)
    );

    typedef struct {
        logic [63:0] sa;
        logic [63:0] sb;
        logic [63:0] ea;
        logic [63:0] eb;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [127:0] sb_q[$];
    logic [63:0]  eA1, eB1, eA2;
    logic [63:0]  m_a, m_b;
    logic         m_v;
    logic [15:0]  m_p;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic iv, input logic [63:0] sa,
                         input logic [63:0] sb, input logic [63:0] ea,
                         input logic [63:0] eb, input logic orr,
                         input logic rs, input logic clr);
        logic         rdy;
        logic         acc;
        logic [127:0] e;
        @(negedge clk);
        in_valid  = iv;
        sumA      = sa;
        sumB      = sb;
        out_ready = orr;
        reset     = rs;
        clear     = clr;
        #1;
        rdy = rs & ~clr & (~m_v | orr);
        acc = iv & rdy;
        chk("in_ready", 64'(in_ready), 64'(rdy));
        chk("in_ready4", 64'(rdy4), 64'(rdy));
        if (acc) sb_q.push_back({ea, eb});
        @(posedge clk);
        #1;
        if (!rs) begin
            m_a = '0; m_b = '0; m_v = 1'b0; m_p = '0;
            eA1 = '0; eB1 = '0; eA2 = '0;
            sb_q.delete();
        end else if (clr) begin
            m_v = 1'b0; m_p = '0;
            eA1 = '0; eB1 = '0; eA2 = '0;
        end else if (acc) begin
            e   = sb_q.pop_front();
            m_a = e[127:64];
            m_b = e[63:0];
            m_v = 1'b1;
            m_p++;
            eA2 = eA1;
            eA1 = ea;
            eB1 = eb;
        end else if (orr) begin
            m_v = 1'b0;
        end
        chk("outA", outA, m_a);
        chk("outB", outB, m_b);
        chk("out_valid", 64'(out_valid), 64'(m_v));
        chk("pairs", 64'(pairs), 64'(m_p));
        chk("pairs4", 64'(p4), 64'(m_p[3:0]));
    endtask

    task automatic send(input logic [63:0] a, input logic [63:0] b,
                        input logic orr);
        logic [63:0] sa;
        logic [63:0] sb;
        sa = a + b + eA1 + eB1;
        sb = b + eA1 + eB1 + eA2;
        cycle(1'b1, sa, sb, a, b, orr, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic orr);
        cycle(1'b0, '0, '0, '0, '0, orr, 1'b1, 1'b0);
    endtask

    vec_t tv[3];

    initial begin
        reset = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sumA = '0; sumB = '0;
        eA1 = '0; eB1 = '0; eA2 = '0;
        m_a = '0; m_b = '0; m_v = 1'b0; m_p = '0;

        do_reset();
        do_reset();
        chk("reset_outA", outA, 64'd0);
        chk("reset_pairs", 64'(pairs), 64'd0);

        tv[0] = '{sa: 64'd3,  sb: 64'd2,  ea: 64'd1, eb: 64'd2};
        tv[1] = '{sa: 64'd10, sb: 64'd7,  ea: 64'd3, eb: 64'd4};
        tv[2] = '{sa: 64'd18, sb: 64'd14, ea: 64'd5, eb: 64'd6};
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, tv[i].sa, tv[i].sb, tv[i].ea, tv[i].eb,
                  1'b1, 1'b1, 1'b0);
            chk("vec_outA", outA, tv[i].ea);
            chk("vec_outB", outB, tv[i].eb);
            if (i == 1) chk("vec_pairs2", 64'(pairs), 64'd2);
        end
        idle(1'b1);

        do_reset();
        send(64'd1, 64'd2, 1'b1);
        cycle(1'b1, 64'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFD,
              1'b1, 1'b1, 1'b0);
        chk("wrap_outB", outB, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("wrap_outA", outA, 64'd0);

        do_reset();
        for (int i = 0; i < 256; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        idle(1'b1);

        send(64'h1111, 64'h2222, 1'b1);
        for (int i = 0; i < 3; i++)
            send(64'h3333 + 64'(i), 64'h4444, 1'b0);
        send(64'h3333, 64'h4444, 1'b1);
        send(64'h5555, 64'h6666, 1'b1);
        chk("bp_outA", outA, 64'h5555);
        idle(1'b1);

        for (int i = 0; i < 5; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        cycle(1'b1, 64'd77, 64'd88, 64'd0, 64'd0, 1'b1, 1'b1, 1'b1);
        chk("clr_valid", 64'(out_valid), 64'd0);
        chk("clr_pairs", 64'(pairs), 64'd0);
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

        for (int i = 0; i < 5; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);
        cycle(1'b1, 64'd77, 64'd88, 64'd0, 64'd0, 1'b1, 1'b0, 1'b0);
        chk("rst_outA", outA, 64'd0);
        chk("rst_outB", outB, 64'd0);
        chk("rst_valid", 64'(out_valid), 64'd0);
        for (int i = 0; i < 4; i++)
            send({$urandom, $urandom}, {$urandom, $urandom}, 1'b1);

        do_reset();
        for (int i = 0; i < 16; i++)
            send(64'(i * 7), 64'(i * 3 + 1), 1'b1);
        chk("cnt4_16", 64'(p4), 64'd0);
        send(64'd9, 64'd9, 1'b1);
        chk("cnt4_17", 64'(p4), 64'd1);
        chk("cnt16_17", 64'(pairs), 64'd17);
        idle(1'b1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
